// File: rtl/tdm_demux_1x8.sv
// 1:8 TDM demultiplexer: rebuilds a parallel word from a serial slot stream framed by a slot-0 sync; TDM_DEMUX_PARITY_EN adds an even-parity slot.
// d/frame_valid update one edge after the final beat; din_valid low stalls all state while pulses self-clear.
module tdm_demux_1x8 #(
  parameter int N_CH   = 8,
  parameter int SLOT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic              din,
  input  logic              fsync,
  output logic [N_CH-1:0]   d,
  output logic              frame_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              sync_err,
  output logic              parity_err
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int L = N_CH + 1;
`else
  localparam int L = N_CH;
`endif
  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(L - 1);

  typedef enum logic {HUNT, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [N_CH-1:0]   cap_q, cap_d;
  logic [N_CH-1:0]   d_q, d_d;
  logic              fv_q, fv_d;
  logic              serr_q, serr_d;
`ifdef TDM_DEMUX_PARITY_EN
  logic              perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cap_d   = cap_q;
    d_d     = d_q;
    fv_d    = 1'b0;
    serr_d  = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    perr_d  = 1'b0;
`endif
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (fsync) begin
            cap_d   = {{(N_CH-1){1'b0}}, din};
            slot_d  = SLOT_W'(1);
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (fsync) begin
            // A sync anywhere but slot 0 restarts the frame from this beat.
            cap_d  = {{(N_CH-1){1'b0}}, din};
            slot_d = SLOT_W'(1);
            if (slot_q != '0) serr_d = 1'b1;
          end else if (slot_q == '0) begin
            serr_d  = 1'b1;
            state_d = HUNT;
            cap_d   = '0;
            slot_d  = '0;
          end else if (slot_q == LAST) begin
`ifdef TDM_DEMUX_PARITY_EN
            d_d    = cap_q;
            perr_d = (^cap_q) ^ din;
`else
            d_d           = cap_q;
            d_d[N_CH-1]   = din;
`endif
            fv_d   = 1'b1;
            cap_d  = '0;
            slot_d = '0;
          end else begin
            for (int i = 1; i < N_CH; i++) begin
              if (slot_q == SLOT_W'(i)) cap_d[i] = din;
            end
            slot_d = slot_q + SLOT_W'(1);
          end
        end
        default: begin
          state_d = HUNT;
          slot_d  = '0;
          cap_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= '0;
      cap_q   <= '0;
      d_q     <= '0;
      fv_q    <= 1'b0;
      serr_q  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cap_q   <= cap_d;
      d_q     <= d_d;
      fv_q    <= fv_d;
      serr_q  <= serr_d;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign d           = d_q;
  assign frame_valid = fv_q;
  assign slot        = slot_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = serr_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Directed bench for tdm_demux_1x8; parity scenarios build only with TDM_DEMUX_PARITY_EN.
module tb_tdm_demux_1x8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       fsync = 1'b0;
  logic [7:0] d;
  logic       frame_valid;
  logic [3:0] slot;
  logic       locked;
  logic       sync_err;
  logic       parity_err;

  int checks = 0;
  int failures = 0;

`ifdef TDM_DEMUX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  tdm_demux_1x8 dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .fsync(fsync),
    .d(d), .frame_valid(frame_valid), .slot(slot), .locked(locked),
    .sync_err(sync_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic beat(input logic v, input logic b, input logic fs);
    @(negedge clk);
    din_valid = v;
    din       = b;
    fsync     = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (d !== 8'h00 || frame_valid !== 1'b0 || slot !== 4'd0 || locked !== 1'b0 ||
        sync_err !== 1'b0 || parity_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: d=%h fv=%b slot=%0d locked=%b serr=%b perr=%b, need all zero",
               d, frame_valid, slot, locked, sync_err, parity_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    beat(1'b0, 1'b1, 1'b1);
    checks++;
    if (locked !== 1'b0 || slot !== 4'd0) begin
      failures++;
      $display("FAIL invalid_fsync_ignored: locked=%b slot=%0d, need 0/0", locked, slot);
    end
    beat(1'b1, 1'b1, 1'b0);
    checks++;
    if (locked !== 1'b0 || slot !== 4'd0) begin
      failures++;
      $display("FAIL hunt_discard: locked=%b slot=%0d, need 0/0", locked, slot);
    end
  endtask

  task automatic test_basic();
    logic [7:0] w;
    int early;
    w = 8'hA5;
    early = 0;
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, w[i], i == 0);
      if (i < 7 && frame_valid !== 1'b0) early++;
    end
    if (PAR) begin
      if (frame_valid !== 1'b0) early++;
      beat(1'b1, ^w, 1'b0);
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL basic_early_fv: %0d early pulses, need 0", early);
    end
    checks++;
    if (d !== 8'hA5 || frame_valid !== 1'b1 || slot !== 4'd0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL basic_frame: d=%h fv=%b slot=%0d locked=%b, need a5/1/0/1",
               d, frame_valid, slot, locked);
    end
    beat(1'b0, 1'b0, 1'b0);
    checks++;
    if (frame_valid !== 1'b0 || d !== 8'hA5) begin
      failures++;
      $display("FAIL basic_fv_clear: fv=%b d=%h, need 0/a5", frame_valid, d);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] w;
    int pulses;
    w = 8'h3C;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, w[i], i == 0);
      if (frame_valid === 1'b1) pulses++;
      if (i == 3) begin
        for (int g = 0; g < 2; g++) begin
          beat(1'b0, 1'b1, 1'b1);
          if (frame_valid === 1'b1) pulses++;
          checks++;
          if (slot !== 4'd4 || d !== 8'hA5 || locked !== 1'b1 || sync_err !== 1'b0) begin
            failures++;
            $display("FAIL gap_hold: slot=%0d d=%h locked=%b serr=%b, need 4/a5/1/0",
                     slot, d, locked, sync_err);
          end
        end
      end
    end
    if (PAR) begin
      beat(1'b1, ^w, 1'b0);
      if (frame_valid === 1'b1) pulses++;
    end
    beat(1'b0, 1'b0, 1'b0);
    if (frame_valid === 1'b1) pulses++;
    checks++;
    if (d !== 8'h3C || pulses != 1) begin
      failures++;
      $display("FAIL gap_frame: d=%h pulses=%0d, need 3c/1", d, pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    int pulses;
    int held_bad;
    pulses = 0;
    held_bad = 0;
    for (int f = 0; f < 2; f++) begin
      w = (f == 0) ? 8'hFF : 8'h00;
      for (int i = 0; i < 8 + int'(PAR); i++) begin
        beat(1'b1, (i < 8) ? w[i] : ^w, i == 0);
        if (frame_valid === 1'b1) pulses++;
        if (f == 1 && i < 7 + int'(PAR) && d !== 8'hFF) held_bad++;
      end
      checks++;
      if (d !== w || frame_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_frame%0d: d=%h fv=%b, need %h/1", f, d, frame_valid, w);
      end
    end
    checks++;
    if (pulses != 2 || held_bad != 0) begin
      failures++;
      $display("FAIL b2b_pulses: pulses=%0d held_bad=%0d, need 2/0", pulses, held_bad);
    end
  endtask

  task automatic test_early_sync();
    logic [7:0] w;
    w = 8'h81;
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b1, w[0], 1'b1);
    checks++;
    if (sync_err !== 1'b1 || locked !== 1'b1 || slot !== 4'd1) begin
      failures++;
      $display("FAIL early_sync_err: serr=%b locked=%b slot=%0d, need 1/1/1", sync_err, locked, slot);
    end
    for (int i = 1; i < 8 + int'(PAR); i++) begin
      beat(1'b1, (i < 8) ? w[i] : ^w, 1'b0);
      if (i == 1) begin
        checks++;
        if (sync_err !== 1'b0) begin
          failures++;
          $display("FAIL early_sync_clear: serr=%b, need 0", sync_err);
        end
      end
    end
    checks++;
    if (d !== 8'h81 || frame_valid !== 1'b1) begin
      failures++;
      $display("FAIL early_sync_frame: d=%h fv=%b, need 81/1", d, frame_valid);
    end
  endtask

  task automatic test_sync_loss();
    beat(1'b1, 1'b1, 1'b0);
    checks++;
    if (sync_err !== 1'b1 || locked !== 1'b0 || slot !== 4'd0) begin
      failures++;
      $display("FAIL loss_detect: serr=%b locked=%b slot=%0d, need 1/0/0", sync_err, locked, slot);
    end
    for (int i = 0; i < 9; i++) beat(1'b1, 1'b1, 1'b0);
    checks++;
    if (locked !== 1'b0 || frame_valid !== 1'b0 || sync_err !== 1'b0 || d !== 8'h81) begin
      failures++;
      $display("FAIL loss_hunt: locked=%b fv=%b serr=%b d=%h, need 0/0/0/81",
               locked, frame_valid, sync_err, d);
    end
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b0);
    checks++;
    if (locked !== 1'b1 || slot !== 4'd3) begin
      failures++;
      $display("FAIL relock: locked=%b slot=%0d, need 1/3", locked, slot);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (d !== 8'h00 || locked !== 1'b0 || slot !== 4'd0) begin
      failures++;
      $display("FAIL async_reset: d=%h locked=%b slot=%0d, need 00/0/0", d, locked, slot);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity();
    logic [7:0] w;
    w = 8'h07;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) beat(1'b1, w[i], i == 0);
      beat(1'b1, (p == 0) ? 1'b1 : 1'b0, 1'b0);
      checks++;
      if (d !== 8'h07 || frame_valid !== 1'b1 || parity_err !== (p == 1)) begin
        failures++;
        $display("FAIL parity_case%0d: d=%h fv=%b perr=%b, need 07/1/%b",
                 p, d, frame_valid, parity_err, p == 1);
      end
    end
    beat(1'b0, 1'b0, 1'b0);
    checks++;
    if (parity_err !== 1'b0) begin
      failures++;
      $display("FAIL parity_clear: perr=%b, need 0", parity_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_early_sync();
    test_sync_loss();
`ifdef TDM_DEMUX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1x8.md
Name: tdm_demux_1x8

Overview:
- Time-division demultiplexer: the receive-side counterpart of the 8:1 mux.
- Accepts a 1-bit serial TDM stream in which slot k carries channel k, framed by a slot-0 sync marker.
- Rebuilds the 8-bit parallel word and presents it with a one-cycle frame_valid pulse.
- Sits at the far end of a serialised link driven by the mux/select-counter path.

Parameters:
- N_CH, 8, channels (data slots) per frame; d width.
- SLOT_W, 4, slot counter width; must satisfy 2^SLOT_W > N_CH so the parity slot is representable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din_valid  input  1  beat qualifier; din/fsync sampled only when high.
- din  input  1  serial data bit for current slot.
- fsync  input  1  frame sync; high on the slot-0 beat only.
- d  output  N_CH  last complete frame; d[k] = slot k bit.
- frame_valid  output  1  one-cycle pulse when d updates.
- slot  output  SLOT_W  index of next expected slot.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on framing error.
- parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 without macro.

Behaviour:
- Reset (async assert, sync release):
  - d=0, frame_valid=0, slot=0, locked=0, sync_err=0, parity_err=0.
  - State HUNT; internal shift/capture register cleared.
- All state changes on rising clk; nothing changes on cycles with din_valid=0, except that pulses self-clear.
- Frame length L = N_CH (N_CH+1 with macro).
- HUNT:
  - Beats without fsync are discarded.
  - A beat with fsync=1 stores din as slot 0, sets slot=1, moves to LOCKED.
- LOCKED, on each beat at slot s:
  - s==0, fsync=1: store din in capture[0], slot=1.
  - s==0, fsync=0: sync_err pulse, discard bit, go HUNT, slot=0, locked=0.
  - 0<s<N_CH, fsync=0: capture[s]=din, slot=s+1.
  - 0<s<L, fsync=1 (early sync): sync_err pulse, drop partial frame, treat beat as new slot 0 (capture[0]=din, slot=1), remain LOCKED.
  - Last slot s==L-1, fsync=0: frame completes. d <= capture with final bit merged; frame_valid=1 next cycle only; slot wraps to 0.
- Latency: final beat sampled at edge t; d/frame_valid visible after edge t; frame_valid deasserts after edge t+1 unless another frame completes (impossible for N_CH>1).
- d holds its value between frames; it is never partially updated.
- fsync with din_valid=0 is ignored.
- Reset mid-frame: partial frame lost; d returns to 0 immediately (async).
- locked = 1 exactly while in LOCKED.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - Frame carries an extra slot N_CH holding even parity.
  - At completion, XOR(data bits, parity bit) must be 0.
  - On mismatch: d still updates and frame_valid pulses, and parity_err pulses the same cycle.
- Undefined:
  - L = N_CH; no parity slot.
  - parity_err tied 0.

Test Plan:
- Reset, then send 8'hA5 LSB-first (slot0=1 with fsync, then 0,1,0,0,1,0,1), back-to-back beats -> d=8'hA5, frame_valid high exactly 1 cycle after the 8th beat edge, slot=0, locked=1.
- Same frame 8'h3C with din_valid low for 2 cycles between slots 3/4 -> d=8'h3C, outputs unchanged during gaps, frame_valid once.
- Two consecutive frames 8'hFF then 8'h00 -> d=8'hFF held between them, then 8'h00; two frame_valid pulses 8 beats apart.
- fsync asserted on slot 3 of a frame, then a full 8'h81 frame from that beat -> sync_err 1 pulse, partial frame dropped, d=8'h81 after 8 beats from the resync.
- After locking, slot-0 beat arrives with fsync=0 -> sync_err pulse, locked=0, bits ignored until next fsync; rst_n pulsed low mid-frame -> d=0, locked=0 immediately.
- With TDM_DEMUX_PARITY_EN: 8'h07 with parity bit 1 -> d=8'h07, parity_err=0; parity bit 0 -> d=8'h07, frame_valid and parity_err pulse together.
